vga_timing_gen: RTL and testbench

// - Parametrised VGA/VESA raster timing generator. Successor to the fixed 640x480 sync generator.
// - Divides clk_100MHz down to a pixel-enable tick, then scans H/V counters over a configurable frame.
// - Outputs: glitch-free registered syncs with selectable polarity, display enable, pixel coordinates,

---
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/VESA raster timing generator.
// The pixel clock is not a real clock. A divider turns clk_100MHz into a pixel-enable
// tick, and H/V counters scan the configured frame in this order: display, front porch,
// sync, back porch.
// Ports:
//   clk_100MHz  in   system clock
//   reset       in   asynchronous, active-high
//   en          in   1 = run, 0 = freeze the divider, the counters and every output
//   p_tick      out  pixel tick, one clk wide (combinational from registers)
//   hsync       out  registered horizontal sync, active level HS_POL
//   vsync       out  registered vertical sync, active level VS_POL
//   video_on    out  registered, 1 while x < H_DISP and y < V_DISP
//   x, y        out  pixel coordinates, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   line_start  out  high on the tick where x wraps to 0
//   frame_start out  high on the tick where x and y both wrap to 0
//   frame_cnt   out  completed frames, modulo 2**FW
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned HS_POL  = 0,
  parameter int unsigned VS_POL  = 0,
  parameter int unsigned CW      = 10,
  parameter int unsigned FW      = 8
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam longint unsigned C_SPAN = 64'd1 << CW;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'((CLK_DIV > 0) ? CLK_DIV - 1 : 0);
  localparam logic [CW-1:0] HMAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VMAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DE    = CW'(H_DISP);
  localparam logic [CW-1:0] V_DE    = CW'(V_DISP);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic          HS_ACT  = 1'(HS_POL);
  localparam logic          VS_ACT  = 1'(VS_POL);

  // Parameter sanity: these configurations cannot produce a valid raster.
  if (CLK_DIV < 1) begin : g_err_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_DISP == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0) begin : g_err_h
    $error("vga_timing_gen: horizontal segment widths must be non-zero");
  end
  if (V_DISP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_v
    $error("vga_timing_gen: vertical segment widths must be non-zero");
  end
  if (CW == 0 || FW == 0) begin : g_err_w
    $error("vga_timing_gen: CW and FW must be non-zero");
  end
  if (longint'(H_TOTAL) > C_SPAN || longint'(V_TOTAL) > C_SPAN) begin : g_err_span
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**CW");
  end

  logic [DW-1:0] r_div_cnt;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [FW-1:0] r_frame_cnt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;

  logic          w_p_tick;
  logic          w_x_at_max;
  logic          w_y_at_max;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;
  logic          w_hsync_next;
  logic          w_vsync_next;
  logic          w_video_on_next;

  // Tick is gated by reset so it stays low while reset is held, even when CLK_DIV=1.
  assign w_p_tick   = en & ~reset & (r_div_cnt == DIV_MAX);
  assign w_x_at_max = (r_x == HMAX);
  assign w_y_at_max = (r_y == VMAX);

  // Next raster position and the sync/enable levels that belong to it.
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_p_tick) begin
      w_x_next = w_x_at_max ? '0 : r_x + CW'(1);
      if (w_x_at_max) begin
        w_y_next = w_y_at_max ? '0 : r_y + CW'(1);
      end
    end
    w_hsync_next    = ((w_x_next >= HS_BEG) && (w_x_next <= HS_END)) ? HS_ACT : ~HS_ACT;
    w_vsync_next    = ((w_y_next >= VS_BEG) && (w_y_next <= VS_END)) ? VS_ACT : ~VS_ACT;
    w_video_on_next = (w_x_next < H_DE) && (w_y_next < V_DE);
  end

  // Pixel-enable divider: free-runs while enabled and holds its phase when en is low.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (en) begin
      r_div_cnt <= (r_div_cnt == DIV_MAX) ? '0 : r_div_cnt + DW'(1);
    end
  end

  // Raster counters and registered timing outputs. All of them load on the same tick,
  // so the syncs and video_on stay aligned with x/y.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
      r_hsync     <= ~HS_ACT;
      r_vsync     <= ~VS_ACT;
      r_video_on  <= 1'b1;
    end else if (w_p_tick) begin
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_hsync    <= w_hsync_next;
      r_vsync    <= w_vsync_next;
      r_video_on <= w_video_on_next;
      if (w_x_at_max && w_y_at_max) begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  assign p_tick      = w_p_tick;
  assign line_start  = w_p_tick & w_x_at_max;
  assign frame_start = w_p_tick & w_x_at_max & w_y_at_max;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. It runs two instances side by side:
//   u_a: default 640x480 timing with CLK_DIV=4 (directed line/freeze/reset cases, then random en)
//   u_b: 8x4 raster with active-high syncs and CLK_DIV=1 (frame wrap, random en and reset)
// The reference model keeps only a count of enabled clocks since reset. It derives the
// tick count, raster position and frame number from that count with integer division.
module tb_vga_timing_gen;

  typedef int unsigned timing_t [12];  // cd, hd, hf, hs, hb, vd, vf, vs, vb, hpol, vpol, fw

  typedef struct {
    int x;
    int y;
    int frame;
    bit tick;
    bit hs;
    bit vs;
    bit von;
    bit ls;
    bit fs;
  } vga_exp_t;

  localparam timing_t T_A = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8};
  localparam timing_t T_B = '{1, 8, 2, 3, 3, 4, 1, 2, 1, 1, 1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_p_tick, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
  logic [9:0] a_x, a_y;
  logic [7:0] a_frame_cnt;
  logic       b_rst, b_en, b_p_tick, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
  logic [3:0] b_x, b_y;
  logic [2:0] b_frame_cnt;

  longint a_clks = 0;
  longint b_clks = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  vga_timing_gen u_a (
    .clk_100MHz(clk), .reset(a_rst), .en(a_en), .p_tick(a_p_tick),
    .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on), .x(a_x), .y(a_y),
    .line_start(a_line_start), .frame_start(a_frame_start), .frame_cnt(a_frame_cnt)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CW(4), .FW(3)
  ) u_b (
    .clk_100MHz(clk), .reset(b_rst), .en(b_en), .p_tick(b_p_tick),
    .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on), .x(b_x), .y(b_y),
    .line_start(b_line_start), .frame_start(b_frame_start), .frame_cnt(b_frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs from the number of enabled clocks since the last reset.
  function automatic vga_exp_t model(input longint clks, input bit en, input bit rst,
                                     input timing_t t);
    vga_exp_t m;
    longint cd    = longint'(t[0]);
    longint ht    = longint'(t[1] + t[2] + t[3] + t[4]);
    longint vt    = longint'(t[5] + t[6] + t[7] + t[8]);
    longint ticks = clks / cd;
    longint pix   = ticks % (ht * vt);
    longint hs0   = longint'(t[1] + t[2]);
    longint vs0   = longint'(t[5] + t[6]);
    m.x     = int'(pix % ht);
    m.y     = int'(pix / ht);
    m.frame = int'((ticks / (ht * vt)) % (longint'(1) << t[11]));
    m.tick  = en && !rst && ((clks % cd) == cd - 1);
    m.hs    = (m.x >= hs0 && m.x < hs0 + longint'(t[3])) ? t[9][0] : ~t[9][0];
    m.vs    = (m.y >= vs0 && m.y < vs0 + longint'(t[7])) ? t[10][0] : ~t[10][0];
    m.von   = (m.x < longint'(t[1])) && (m.y < longint'(t[5]));
    m.ls    = m.tick && (m.x == ht - 1);
    m.fs    = m.ls && (m.y == vt - 1);
    return m;
  endfunction

  task automatic step_a(input bit rst, input bit en);
    vga_exp_t m;
    @(negedge clk);
    a_rst = rst;
    a_en  = en;
    #1;
    if (rst) a_clks = 0;
    m = model(a_clks, en, rst, T_A);
    check("a_x", 32'(a_x), 32'(m.x));
    check("a_y", 32'(a_y), 32'(m.y));
    check("a_frame", 32'(a_frame_cnt), 32'(m.frame));
    check("a_tick", 32'(a_p_tick), 32'(m.tick));
    check("a_hsync", 32'(a_hsync), 32'(m.hs));
    check("a_vsync", 32'(a_vsync), 32'(m.vs));
    check("a_von", 32'(a_video_on), 32'(m.von));
    check("a_lstart", 32'(a_line_start), 32'(m.ls));
    check("a_fstart", 32'(a_frame_start), 32'(m.fs));
    @(posedge clk);
    if (!rst && en) a_clks++;
  endtask

  task automatic step_b(input bit rst, input bit en);
    vga_exp_t m;
    @(negedge clk);
    b_rst = rst;
    b_en  = en;
    #1;
    if (rst) b_clks = 0;
    m = model(b_clks, en, rst, T_B);
    check("b_x", 32'(b_x), 32'(m.x));
    check("b_y", 32'(b_y), 32'(m.y));
    check("b_frame", 32'(b_frame_cnt), 32'(m.frame));
    check("b_tick", 32'(b_p_tick), 32'(m.tick));
    check("b_hsync", 32'(b_hsync), 32'(m.hs));
    check("b_vsync", 32'(b_vsync), 32'(m.vs));
    check("b_von", 32'(b_video_on), 32'(m.von));
    check("b_lstart", 32'(b_line_start), 32'(m.ls));
    check("b_fstart", 32'(b_frame_start), 32'(m.fs));
    @(posedge clk);
    if (!rst && en) b_clks++;
  endtask

  task automatic run_a();
    int guard;
    int hs_first = -1;
    int hs_last  = -1;
    int von_off  = -1;
    int ls_x     = -1;
    // Reset state and first pixel advance.
    repeat (3) step_a(1'b1, 1'b0);
    #1;
    check("a_rst_x", 32'(a_x), 32'd0);
    check("a_rst_hs", 32'(a_hsync), 32'd1);
    check("a_rst_von", 32'(a_video_on), 32'd1);
    repeat (4) step_a(1'b0, 1'b1);
    #1;
    check("a_first_adv", 32'(a_x), 32'd1);
    // Run to x=100, freeze for 37 clks, then resume.
    guard = 0;
    while (model(a_clks, 1'b1, 1'b0, T_A).x != 100 && guard < 1000) begin
      step_a(1'b0, 1'b1);
      guard++;
    end
    repeat (37) step_a(1'b0, 1'b0);
    #1;
    check("a_frozen_x", 32'(a_x), 32'd100);
    repeat (4) step_a(1'b0, 1'b1);
    #1;
    check("a_resume_x", 32'(a_x), 32'd101);
    // Observe line 1 end to end.
    guard = 0;
    while (model(a_clks, 1'b1, 1'b0, T_A).y < 2 && guard < 10000) begin
      step_a(1'b0, 1'b1);
      #1;
      if (a_y == 10'd1) begin
        if (!a_hsync) begin
          if (hs_first < 0) hs_first = int'(a_x);
          hs_last = int'(a_x);
        end
        if (!a_video_on && von_off < 0) von_off = int'(a_x);
        if (a_line_start) ls_x = int'(a_x);
      end
      guard++;
    end
    check("a_line_guard", 32'(guard < 10000), 32'd1);
    check("a_hs_first", 32'(hs_first), 32'd656);
    check("a_hs_last", 32'(hs_last), 32'd751);
    check("a_von_off", 32'(von_off), 32'd640);
    check("a_lstart_x", 32'(ls_x), 32'd799);
    // Reset mid-line returns to the reset state at once.
    guard = 0;
    while (model(a_clks, 1'b1, 1'b0, T_A).x != 400 && guard < 8000) begin
      step_a(1'b0, 1'b1);
      guard++;
    end
    step_a(1'b1, 1'b1);
    #1;
    check("a_mid_rst_x", 32'(a_x), 32'd0);
    check("a_mid_rst_y", 32'(a_y), 32'd0);
    check("a_mid_rst_vs", 32'(a_vsync), 32'd1);
    check("a_mid_rst_fr", 32'(a_frame_cnt), 32'd0);
    // Random enable pattern with occasional reset.
    for (int i = 0; i < 12000; i++) begin
      step_a(($urandom % 3000) == 0, ($urandom % 5) != 0);
    end
  endtask

  task automatic run_b();
    repeat (2) step_b(1'b1, 1'b1);
    #1;
    check("b_rst_tick", 32'(b_p_tick), 32'd0);
    check("b_rst_hs", 32'(b_hsync), 32'd0);
    // Nine full 16x8 frames: frame_cnt wraps modulo 8.
    repeat (128 * 9) step_b(1'b0, 1'b1);
    #1;
    check("b_frames", 32'(b_frame_cnt), 32'd1);
    check("b_frames_x", 32'(b_x), 32'd0);
    check("b_tick_const", 32'(b_p_tick), 32'd1);
    for (int i = 0; i < 20000; i++) begin
      step_b(($urandom % 700) == 0, ($urandom % 10) != 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b1;
    a_en  = 1'b0;
    b_rst = 1'b1;
    b_en  = 1'b0;
    fork
      run_a();
      run_b();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
